cfu_issue: RTL
==============

# cfu_issue

Issue/retire front-end between the CPU execute stage and the custom function unit (CFU). Accepts one decoded CFU instruction at a time from the pipeline and registers its operands. Drives the CFU's one-cycle enable/ctrl/operand handshake and waits out the CFU stall. Holds the result in a register until the writeback stage takes it, with an optional watchdog that aborts a hung CFU operation.

## Interface
- `TIMEOUT_CYCLES`, default 256 — max cycles spent in WAIT before abort (used only with `CFU_TIMEOUT_EN`)
- `clk_i` in 1 — clock
- `rst_i` in 1 — reset; asynchronous, active-high
- `in_valid_i` in 1 — pipeline offers a CFU instruction
- `in_ready_o` out 1 — block can accept (IDLE only)
- `in_ctrl_i` in 10 — {funct7, funct3}
- `in_src1_i` / `in_src2_i` in 32 — rs1/rs2 values
- `in_rd_i` in 5 — destination register
- `flush_i` in 1 — kill the in-flight instruction (mispredict/trap)
- `cfu_en_o` out 1 — one-cycle issue pulse to the CFU
- `cfu_ctrl_o` out 10 — registered ctrl
- `cfu_src1_o` / `cfu_src2_o` out 32 — registered operands
- `cfu_stall_i` in 1 — CFU busy
- `cfu_rslt_i` in 32 — CFU result
- `wb_valid_o` out 1 — result available
- `wb_ready_i` in 1 — writeback consumes
- `wb_rd_o` out 5, `wb_data_o` out 32, `wb_err_o` out 1 — destination, result, timeout flag
- `busy_o` out 1 — high in any state other than IDLE; stalls the front of the pipeline

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: `in_ready_o`=1. On `in_valid_i`, latch ctrl, src1, src2 and rd, then go to ISSUE. If `flush_i` is high in the same cycle, the offer is ignored.
- ISSUE: `cfu_en_o`=1 for exactly this cycle, with ctrl/src outputs stable. Next state is WAIT, or DRAIN if `flush_i` is high.
- WAIT: each cycle `cfu_stall_i`=0, latch `cfu_rslt_i` into `wb_data_o` and go to DONE. Otherwise stay.
  - The CFU contract is: stall is asserted from the cycle after `en`, and the result is valid in the first cycle stall is low.
  - If `flush_i` is high in WAIT, go to DRAIN. If stall is already low in that cycle, go to IDLE and discard the result.
- DONE: `wb_valid_o`=1. Data, rd and err are held stable until `wb_ready_i`, then go to IDLE.
  - A flush in DONE drops `wb_valid_o` and returns to IDLE; the instruction is not retired.
- DRAIN: wait for `cfu_stall_i`=0 and discard the result, then go to IDLE. The CFU is never re-issued while it is stalled.
- `cfu_ctrl_o`/`cfu_src*_o` hold their last values outside ISSUE. Only `cfu_en_o` qualifies them.
- Reset (asynchronous, including mid-operation): state=IDLE. All outputs are 0 except `in_ready_o`=1. Registered data fields are cleared to 0.
- Back-to-back: a new instruction is accepted only in IDLE. Minimum spacing is one IDLE cycle after DONE.

## Timing
- Accept at cycle T; `cfu_en_o` at T+1.
- For a CFU that stalls one cycle (stall at T+2, result at T+3): capture at T+3 and `wb_valid_o` at T+4. Accept-to-writeback latency is 4 cycles.
- The CFU can never stall: capture at T+2 and `wb_valid_o` at T+3.
- `wb_valid_o` must not drop without `wb_ready_i` or `flush_i`.
- All outputs are registered. No combinational path from `cfu_*_i` to `wb_*_o` or `in_ready_o`.

## Configuration
- `CFU_TIMEOUT_EN` defined:
  - A cycle counter clears on entering WAIT or DRAIN and increments every cycle in those states.
  - When it reaches `TIMEOUT_CYCLES` in WAIT: go to DONE with `wb_data_o`=0 and `wb_err_o`=1.
  - When it reaches `TIMEOUT_CYCLES` in DRAIN: go to IDLE.
  - The counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `CFU_TIMEOUT_EN` undefined: no counter, WAIT and DRAIN are unbounded, and `wb_err_o` is tied to 0.

## Structure
- Shared package `cfu_pkg` holds:
  - the state enum;
  - `CFU_CTRL_W`=10, `XLEN`=32, `REG_ADDR_W`=5;
  - the `cfu_req_t` struct (ctrl, src1, src2, rd).
- One sub-module, `cfu_watchdog`: counter with `clear`, `count_en` and a `expired` flag, instantiated only under `CFU_TIMEOUT_EN`.

## Test plan
- Accept ctrl=0, src1=5, src2=7 against the one-stall CFU model → one `cfu_en_o` pulse at T+1, `wb_valid_o` at T+4 with data=12, rd echoed, err=0.
- Hold `wb_ready_i`=0 for 5 cycles in DONE → data/rd stable and `in_ready_o`=0 throughout; retire on the ready cycle, `in_ready_o`=1 the next cycle.
- `flush_i` in WAIT while the CFU stalls 3 more cycles → no `wb_valid_o`; `busy_o` stays high until stall drops, then IDLE; no second `cfu_en_o`.
- Assert `rst_i` asynchronously mid-WAIT → outputs go to reset values immediately; the next instruction (src 1, 2) retires data=3.
- With `CFU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, CFU stall held high → `wb_valid_o` with data=0 and err=1 exactly 8 cycles after entering WAIT.
- Zero-stall CFU model with 3 back-to-back instructions and `wb_ready_i`=1 → results in order, each accept spaced 4 cycles apart.

Source files
------------

// File: rtl/cfu_pkg.sv
// rtl/cfu_pkg.sv - shared types and widths for the CFU issue front-end
// Purpose: FSM state enum, datapath widths and the registered request struct
//          used by cfu_issue and cfu_watchdog.
package cfu_pkg;

    localparam int CFU_CTRL_W = 10;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } cfu_state_e;

    typedef struct packed {
        logic [CFU_CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]       src1;
        logic [XLEN-1:0]       src2;
        logic [REG_ADDR_W-1:0] rd;
    } cfu_req_t;

endpackage

// File: rtl/cfu_watchdog.sv
// rtl/cfu_watchdog.sv - cycle counter that flags a hung CFU operation
// Purpose: counts cycles while count_en_i is high, restarts on clear_i.
// Ports:   clk_i, rst_i (async, active-high), clear_i, count_en_i,
//          expired_o (high in the cycle the count steps up to LIMIT).
module cfu_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a long stall never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag the cycle whose increment makes the count reach LIMIT, so the
    // owner leaves its state exactly LIMIT cycles after entering it.
    assign expired_o = count_en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cfu_issue.sv
// rtl/cfu_issue.sv - issue/retire front-end between execute stage and CFU
// Purpose: accepts one CFU instruction, registers its operands, pulses the
//          CFU enable, waits out the CFU stall and holds the result until
//          writeback takes it. Optional watchdog under macro CFU_TIMEOUT_EN.
// Ports:   clk_i, rst_i (async, active-high)
//          in_valid_i/in_ready_o, in_ctrl_i, in_src1_i, in_src2_i, in_rd_i
//          flush_i
//          cfu_en_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o, cfu_stall_i, cfu_rslt_i
//          wb_valid_o/wb_ready_i, wb_rd_o, wb_data_o, wb_err_o
//          busy_o
module cfu_issue
    import cfu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CFU_CTRL_W-1:0] in_ctrl_i,
    input  logic [XLEN-1:0]       in_src1_i,
    input  logic [XLEN-1:0]       in_src2_i,
    input  logic [REG_ADDR_W-1:0] in_rd_i,
    input  logic                  flush_i,
    output logic                  cfu_en_o,
    output logic [CFU_CTRL_W-1:0] cfu_ctrl_o,
    output logic [XLEN-1:0]       cfu_src1_o,
    output logic [XLEN-1:0]       cfu_src2_o,
    input  logic                  cfu_stall_i,
    input  logic [XLEN-1:0]       cfu_rslt_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  wb_err_o,
    output logic                  busy_o
);

    cfu_state_e      state_q, state_d;
    cfu_req_t        req_q, req_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            timeout;
    logic            accept;
    logic            capture;

`ifdef CFU_TIMEOUT_EN
    logic err_q, err_d;

    // Any state change restarts the count, which covers entry into both
    // WAIT and DRAIN (including WAIT -> DRAIN on a flush).
    cfu_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_d != state_q),
        .count_en_i((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
        .expired_o (timeout)
    );

    // A capture with stall still high can only be a timeout.
    always_comb begin
        err_d = err_q;
        if (capture) begin
            err_d = cfu_stall_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign wb_err_o = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign wb_err_o           = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid_i && !flush_i) state_d = ST_ISSUE;
            ST_ISSUE: state_d = flush_i ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                // A flush with the result already present needs no drain.
                if (flush_i) begin
                    state_d = cfu_stall_i ? ST_DRAIN : ST_IDLE;
                end else if (!cfu_stall_i || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  if (wb_ready_i || flush_i) state_d = ST_IDLE;
            ST_DRAIN: if (!cfu_stall_i || timeout) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: every output comes from a register, never from cfu_*_i.
    always_comb begin
        in_ready_o = (state_q == ST_IDLE);
        busy_o     = (state_q != ST_IDLE);
        cfu_en_o   = (state_q == ST_ISSUE);
        wb_valid_o = (state_q == ST_DONE);
    end

    // Request and result registers
    always_comb begin
        accept  = (state_q == ST_IDLE) && in_valid_i && !flush_i;
        capture = (state_q == ST_WAIT) && !flush_i && (!cfu_stall_i || timeout);
        req_d   = req_q;
        data_d  = data_q;
        if (accept) begin
            req_d.ctrl = in_ctrl_i;
            req_d.src1 = in_src1_i;
            req_d.src2 = in_src2_i;
            req_d.rd   = in_rd_i;
        end
        // A real result wins over a timeout landing in the same cycle.
        if (capture) begin
            data_d = cfu_stall_i ? '0 : cfu_rslt_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= '0;
            data_q <= '0;
        end else begin
            req_q  <= req_d;
            data_q <= data_d;
        end
    end

    assign cfu_ctrl_o = req_q.ctrl;
    assign cfu_src1_o = req_q.src1;
    assign cfu_src2_o = req_q.src2;
    assign wb_rd_o    = req_q.rd;
    assign wb_data_o  = data_q;

endmodule
